// File: rtl/led_matrix_scanner.sv
// Double-buffered LED matrix scanner: the CPU writes rows into a back
// buffer while the front buffer is time-multiplexed onto the matrix pins
// with per-row blanking and 4-bit PWM column gating. Buffers exchange
// roles only at frame boundaries, so a frame is never shown half-updated.
module led_matrix_scanner #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int ROW_CYCLES     = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter int OUT_ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [ROWS-1:0] wr_row,
    input  logic [COLS-1:0] wr_col,
    input  logic            swap,
    input  logic [3:0]      brightness,
    output logic            swap_pending,
    output logic            frame_start,
    output logic [ROWS-1:0] row_out,
    output logic [COLS-1:0] col_out
);

    localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(ROW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    generate
        if (ROW_CYCLES <= BLANK_CYCLES || ROW_CYCLES > 65536) begin : g_bad_params
            $error("led_matrix_scanner: ROW_CYCLES must exceed BLANK_CYCLES and be at most 65536");
        end
    endgenerate

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [RW-1:0]   ridx_q, ridx_d;
    logic [3:0]      pwm_q, pwm_d;
    logic [COLS-1:0] latch_q, latch_d;
    logic            front_q, front_d;
    logic            swap_pending_q, swap_pending_d;
    logic [ROWS-1:0] row_reg_q, row_reg_d;
    logic [COLS-1:0] col_reg_q, col_reg_d;

    logic [COLS-1:0] front_rows [ROWS];
    logic            cyc_last, row_last, boundary, drive_first;
    logic [COLS-1:0] pattern;

    // Frame buffer: per row, two entries; the one not selected by front_q is the write target.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [COLS-1:0] buf0_q, buf0_d, buf1_q, buf1_d;

            // Write the back copy of this row when it is selected.
            always_comb begin
                buf0_d = buf0_q;
                buf1_d = buf1_q;
                if (wr_en && wr_row[gi]) begin
                    if (front_q) buf0_d = wr_col;
                    else         buf1_d = wr_col;
                end
            end

            // Row storage registers, cleared on reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    buf0_q <= '0;
                    buf1_q <= '0;
                end else begin
                    buf0_q <= buf0_d;
                    buf1_q <= buf1_d;
                end
            end

            assign front_rows[gi] = front_q ? buf1_q : buf0_q;
        end
    endgenerate

    assign cyc_last    = (cyc_q == CYC_LAST);
    assign row_last    = (ridx_q == ROW_LAST);
    assign boundary    = cyc_last && row_last;
    assign drive_first = (state_q == ST_DRIVE) && (cyc_q == BLANK_C);
    // The first drive cycle shows the row straight from the buffer; later cycles use the latch.
    assign pattern     = drive_first ? front_rows[ridx_q] : latch_q;

    // Scan counters, phase FSM, PWM, row latch, swap handling and next pin values.
    always_comb begin
        cyc_d          = cyc_last ? '0 : cyc_q + 1'b1;
        ridx_d         = cyc_last ? (row_last ? '0 : ridx_q + 1'b1) : ridx_q;
        state_d        = (cyc_d < BLANK_C) ? ST_BLANK : ST_DRIVE;
        pwm_d          = '0;
        latch_d        = drive_first ? front_rows[ridx_q] : latch_q;
        front_d        = front_q;
        swap_pending_d = swap_pending_q | swap;
        row_reg_d      = '0;
        col_reg_d      = '0;

        if (state_q == ST_DRIVE) begin
            // Slot end clears PWM so the next slot's first drive cycle starts at 0.
            pwm_d     = cyc_last ? 4'd0 : pwm_q + 4'd1;
            row_reg_d = {{(ROWS-1){1'b0}}, 1'b1} << ridx_q;
            if (pwm_q < brightness) col_reg_d = pattern;
        end

        if (boundary) begin
            if (swap_pending_q) begin
                front_d        = ~front_q;
                swap_pending_d = 1'b0;
            end else begin
                swap_pending_d = swap;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_BLANK;
            cyc_q          <= '0;
            ridx_q         <= '0;
            pwm_q          <= '0;
            latch_q        <= '0;
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            row_reg_q      <= '0;
            col_reg_q      <= '0;
        end else begin
            state_q        <= state_d;
            cyc_q          <= cyc_d;
            ridx_q         <= ridx_d;
            pwm_q          <= pwm_d;
            latch_q        <= latch_d;
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
            row_reg_q      <= row_reg_d;
            col_reg_q      <= col_reg_d;
        end
    end

    assign row_out      = (OUT_ACTIVE_LOW != 0) ? ~row_reg_q : row_reg_q;
    assign col_out      = (OUT_ACTIVE_LOW != 0) ? ~col_reg_q : col_reg_q;
    assign swap_pending = swap_pending_q;
    assign frame_start  = !reset && (cyc_q == '0) && (ridx_q == '0);

endmodule
